// File: rtl/approx_mul_pipe_if.sv
// Streaming operand/result handshake bundle for approx_mul_pipe.
interface approx_mul_pipe_if #(
  parameter int unsigned W = 8
);
  logic           i_valid;
  logic           i_ready;
  logic [W-1:0]   i_a;
  logic [W-1:0]   i_b;
  logic [1:0]     i_mode;
  logic           o_valid;
  logic           o_ready;
  logic [2*W-1:0] o_p;
  logic [1:0]     o_mode;

  // Upstream/downstream environment side.
  modport master (
    output i_valid, i_a, i_b, i_mode, o_ready,
    input  i_ready, o_valid, o_p, o_mode
  );

  // Multiplier side.
  modport slave (
    input  i_valid, i_a, i_b, i_mode, o_ready,
    output i_ready, o_valid, o_p, o_mode
  );
endinterface

// File: rtl/approx_mul_pipe.sv
// Pipelined unsigned W x W multiplier with exact / truncated / compensated
// modes and on-line delivered-count and absolute-error statistics.
module approx_mul_pipe #(
  parameter int unsigned W       = 8,
  parameter int unsigned TRUNC_K = 4,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned ACC_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  approx_mul_pipe_if.slave   bus,
  input  logic               clr_stats,
  output logic [ACC_W-1:0]   stat_cnt,
  output logic [ACC_W-1:0]   stat_err
);

  localparam int unsigned PW  = 2 * W;
  localparam int unsigned CSH = (TRUNC_K >= 1) ? TRUNC_K - 1 : 0;
  localparam int unsigned SW  = ((ACC_W > PW) ? ACC_W : PW) + 1;

  // Keeps only partial-product columns at or above TRUNC_K.
  localparam logic [PW-1:0] TMASK = ~((PW'(1) << TRUNC_K) - PW'(1));
  localparam logic [PW-1:0] COMP  = (TRUNC_K >= 1) ? (PW'(1) << CSH) : '0;
  localparam logic [SW-1:0] SAT   = (SW'(1) << ACC_W) - SW'(1);

  logic [PW-1:0] exact_c;
  logic [PW-1:0] trunc_c;
  logic [PW-1:0] approx_c;
  logic          stall_c;
  logic          deliver_c;
  logic [PW-1:0] err_c;
  logic [SW-1:0] sum_c;

  logic          v_q    [STAGES];
  logic          v_d    [STAGES];
  logic [PW-1:0] p_q    [STAGES];
  logic [PW-1:0] p_d    [STAGES];
  logic [PW-1:0] x_q    [STAGES];
  logic [PW-1:0] x_d    [STAGES];
  logic [1:0]    mode_q [STAGES];
  logic [1:0]    mode_d [STAGES];

  logic [ACC_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] err_q, err_d;

  // Exact and column-truncated products of the incoming beat; each shifted
  // row is masked so only its bits in retained columns contribute.
  always_comb begin
    exact_c = PW'(bus.i_a) * PW'(bus.i_b);
    trunc_c = '0;
    for (int i = 0; i < W; i++) begin
      if (bus.i_a[i]) begin
        trunc_c = trunc_c + ((PW'(bus.i_b) << i) & TMASK);
      end
    end
    case (bus.i_mode)
      2'd1:    approx_c = trunc_c;
      2'd2:    approx_c = trunc_c + COMP;
      default: approx_c = exact_c;
    endcase
  end

  // Whole pipe freezes (bubbles included) while the output is held.
  assign stall_c     = v_q[STAGES-1] && !bus.o_ready;
  assign deliver_c   = v_q[STAGES-1] && bus.o_ready;
  assign bus.i_ready = !stall_c;
  assign bus.o_valid = v_q[STAGES-1];
  assign bus.o_p     = p_q[STAGES-1];
  assign bus.o_mode  = mode_q[STAGES-1];

  // Next pipeline contents: shift one stage when not stalled, else hold.
  always_comb begin
    v_d    = v_q;
    p_d    = p_q;
    x_d    = x_q;
    mode_d = mode_q;
    if (!stall_c) begin
      v_d[0]    = bus.i_valid;
      p_d[0]    = approx_c;
      x_d[0]    = exact_c;
      mode_d[0] = bus.i_mode;
      for (int s = 1; s < STAGES; s++) begin
        v_d[s]    = v_q[s-1];
        p_d[s]    = p_q[s-1];
        x_d[s]    = x_q[s-1];
        mode_d[s] = mode_q[s-1];
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s]    <= 1'b0;
        p_q[s]    <= '0;
        x_q[s]    <= '0;
        mode_q[s] <= 2'd0;
      end
    end else begin
      v_q    <= v_d;
      p_q    <= p_d;
      x_q    <= x_d;
      mode_q <= mode_d;
    end
  end

  // Absolute error of the result at the output; compensation may overshoot.
  always_comb begin
    if (x_q[STAGES-1] >= p_q[STAGES-1]) begin
      err_c = x_q[STAGES-1] - p_q[STAGES-1];
    end else begin
      err_c = p_q[STAGES-1] - x_q[STAGES-1];
    end
  end

  // Statistics update: clear wins over a same-cycle delivery.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    sum_c = SW'(err_q) + SW'(err_c);
    if (clr_stats) begin
      cnt_d = '0;
      err_d = '0;
    end else if (deliver_c) begin
      cnt_d = cnt_q + ACC_W'(1);
      err_d = (sum_c > SAT) ? '1 : ACC_W'(sum_c);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign stat_cnt = cnt_q;
  assign stat_err = err_q;

endmodule

// File: doc/approx_mul_pipe.md
Name: approx_mul_pipe

Overview:
- Parametrised, pipelined unsigned W x W multiplier with a per-transaction approximation mode.
- Modes: exact, column-truncated, and column-truncated with constant compensation.
- Carries a valid/ready handshake so it drops into streaming datapaths.
- Keeps on-line error statistics (delivered-sample count, accumulated absolute error) so approximation quality can be measured in silicon.

Parameters:
- W, 8, operand width in bits; legal range 2..16.
- TRUNC_K, 4, partial-product columns dropped in approximate modes; legal 0..W.
- STAGES, 2, pipeline depth = latency in cycles from acceptance to o_valid; legal 1..4.
- ACC_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  operand/mode beat valid.
- i_ready  out  1  block can accept a beat this cycle.
- i_a  in  W  operand A, unsigned.
- i_b  in  W  operand B, unsigned.
- i_mode  in  2  0=exact, 1=truncate, 2=truncate+compensate, 3=reserved (treated as exact).
- o_valid  out  1  result valid.
- o_ready  in  1  downstream accepts result.
- o_p  out  2W  product, per the mode captured with the operands.
- o_mode  out  2  mode that produced o_p, as captured.
- clr_stats  in  1  synchronous clear of statistics.
- stat_cnt  out  ACC_W  results delivered since reset/clear; wraps modulo 2^ACC_W.
- stat_err  out  ACC_W  sum of |exact - o_p| over delivered results; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0):
  - o_valid=0, o_p=0, o_mode=0, stat_cnt=0, stat_err=0; all pipeline valid bits cleared.
  - Any in-flight beats are discarded.
  - i_ready reads 1 while in reset.
- Handshake and stall:
  - A beat is accepted when i_valid && i_ready; a result is delivered when o_valid && o_ready.
  - stall = o_valid && !o_ready; i_ready = !stall (combinational).
  - While stalled, every pipeline stage holds, including bubbles; bubbles are not collapsed.
  - o_p and o_mode stay stable while o_valid && !o_ready.
- Latency and throughput:
  - With no stall, the result appears exactly STAGES cycles after acceptance (o_valid high in cycle t+STAGES).
  - Throughput is one beat per cycle; results leave in acceptance order.
- Arithmetic (full 2W-bit, no overflow):
  - exact = i_a*i_b.
  - trunc = sum of a_i*b_j*2^(i+j) over all i+j >= TRUNC_K.
  - comp = trunc + 2^(TRUNC_K-1) when TRUNC_K >= 1, otherwise trunc.
  - TRUNC_K=0 makes modes 1 and 2 identical to exact.
- Pipeline contents:
  - The exact product travels alongside the approximate product so error is formed at the output stage.
  - err = |exact - o_p|, computed as a 2W-bit magnitude.
- Statistics:
  - On each delivery: stat_cnt += 1 (wraps) and stat_err += err (saturating).
  - clr_stats=1 zeroes both next cycle and takes priority over a same-cycle delivery; that delivery is not counted.
  - Statistics never affect the datapath.
- Mode rules:
  - Mode is sampled per beat; changing i_mode mid-stream affects only subsequently accepted beats.
  - Mode 3 yields the exact product, o_mode=3, err=0.

Test Plan:
- W=8,K=4,STAGES=2; accept A=255,B=255 in modes 0,1,2 back-to-back, o_ready=1 -> o_p=65025, 64976, 64984 on consecutive cycles from t+2; stat_cnt=3, stat_err=0+49+41=90.
- A=3,B=3 mode 1 then mode 2 -> o_p=0 (err 9), then o_p=8 (err 1).
- Hold o_ready=0 with 2 beats in flight -> i_ready=0 once o_valid rises, o_p stable for 5 cycles; release -> both results delivered in order on consecutive cycles, no loss or duplication.
- Random 10k beats, random i_valid/o_ready/i_mode -> every o_p matches the model formula, order preserved, stat_cnt equals delivery count, stat_err equals model sum.
- Pulse clr_stats in the same cycle as a delivery -> stat_cnt=0 and stat_err=0 next cycle; preload near-max error with ACC_W=8 -> stat_err sticks at 255.
- Deassert rst_n mid-stream with 2 beats in flight -> o_valid=0 and stats zero immediately; after release, the first result is from a newly accepted beat only.
